qpix_ts_capture: RTL

Parametrised multi-channel timestamp capture for the QPix readout path, running in the 200 MHz capture domain. Each enabled LVDS reset-replenishment line is synchronised and edge-detected, and the free-running timestamp is latched per channel. Pending captures are merged by a round-robin arbiter into one shared first-word-fall-through FIFO of `{channel id, timestamp}` words that the readout side drains. It replaces per-channel single-FIFO logic and adds channel tagging, a selectable depth and width, and dropped-event accounting.

---
 rtl/qpix_ts_capture.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/qpix_ts_capture.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : qpix_ts_capture                                            |
// | Description : Multi-channel LVDS edge timestamp capture. Each enabled    |
// |               input is synchronised and edge-detected, and the free-     |
// |               running counter is latched per channel. A round-robin      |
// |               arbiter merges pending captures into one shared FWFT FIFO  |
// |               of {ch_id, ts} words, and lost events are counted.         |
// | Option      : TS_CAPTURE_FALLING_EN - also capture falling edges; words  |
// |               then carry an MSB edge bit (1 = rising, 0 = falling).      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module qpix_ts_capture #(
  parameter int NCH         = 16,
  parameter int TS_W        = 48,
  parameter int DEPTH       = 64,
  parameter int SYNC_STAGES = 2,
  localparam int CH_W       = $clog2(NCH),
`ifdef TS_CAPTURE_FALLING_EN
  localparam int EDGE_W     = 1,
`else
  localparam int EDGE_W     = 0,
`endif
  localparam int OUT_W      = EDGE_W + CH_W + TS_W,
  localparam int LVL_W      = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   i_lvds_in,
  input  logic [NCH-1:0]   i_ch_enable,
  input  logic             i_counter_reset,
  input  logic             i_rd_en,
  output logic [OUT_W-1:0] o_dout,
  output logic             o_empty,
  output logic             o_full,
  output logic [LVL_W-1:0] o_level,
  output logic [15:0]      o_drop_count,
  output logic [TS_W-1:0]  o_ts_now
);

  localparam int                 c_AW        = $clog2(DEPTH);
  localparam int                 c_SUP_W     = 3;
  localparam logic [c_SUP_W-1:0] c_SUP_INIT  = c_SUP_W'(SYNC_STAGES + 1);
  localparam logic [LVL_W-1:0]   c_DEPTH_LVL = LVL_W'(DEPTH);
  localparam logic [CH_W:0]      c_NCH       = (CH_W+1)'(NCH);
  localparam logic [CH_W-1:0]    c_LAST_CH   = CH_W'(NCH - 1);

  logic [TS_W-1:0]    r_cnt;
  logic [NCH-1:0]     r_sync [SYNC_STAGES];
  logic [NCH-1:0]     r_prev;
  logic [NCH-1:0]     r_pend;
  logic [TS_W-1:0]    r_ts_lat [NCH];
`ifdef TS_CAPTURE_FALLING_EN
  logic [NCH-1:0]     r_edge_lat;
`endif
  logic [c_SUP_W-1:0] r_sup;
  logic [CH_W-1:0]    r_rr;
  logic [15:0]        r_drop;
  logic [OUT_W-1:0]   r_mem [DEPTH];
  logic [c_AW-1:0]    r_wptr;
  logic [c_AW-1:0]    r_rptr;
  logic [LVL_W-1:0]   r_level;
  logic               r_out_vld;
  logic [OUT_W-1:0]   r_dout;

  logic [NCH-1:0]     w_sync;
  logic [NCH-1:0]     w_rise;
  logic [NCH-1:0]     w_evt;
  logic               w_det_en;
  logic               w_full;
  logic               w_gnt_vld;
  logic [CH_W-1:0]    w_gnt_id;
  logic [CH_W:0]      w_rot_idx;
  logic [NCH-1:0]     w_gnt_oh;
  logic [NCH-1:0]     w_drop;
  logic [CH_W:0]      w_drop_n;
  logic [16:0]        w_drop_sum;
  logic [OUT_W-1:0]   w_wr_word;
  logic               w_pop;
  logic               w_load;
  logic [LVL_W-1:0]   w_mem_cnt;

  // Free-running timestamp counter with synchronous zeroing
  always_ff @(posedge clk) begin
    if (rst || i_counter_reset) r_cnt <= '0;
    else                        r_cnt <= r_cnt + 1'b1;
  end

  // Input synchronisers, edge-history register and post-reset blanking counter
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
      r_prev <= '0;
      r_sup  <= c_SUP_INIT;
    end else begin
      r_sync[0] <= i_lvds_in;
      for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
      r_prev <= w_sync;
      if (r_sup != '0) r_sup <= r_sup - 1'b1;
    end
  end

  assign w_sync   = r_sync[SYNC_STAGES-1];
  assign w_rise   = w_sync & ~r_prev;
  // Blanking keeps an input that is already high at reset release silent
  assign w_det_en = (r_sup == '0);
`ifdef TS_CAPTURE_FALLING_EN
  assign w_evt    = (w_rise | (~w_sync & r_prev)) & i_ch_enable & {NCH{w_det_en}};
`else
  assign w_evt    = w_rise & i_ch_enable & {NCH{w_det_en}};
`endif

  assign w_full = (r_level == c_DEPTH_LVL);

  // Round-robin grant: first pending channel at or after r_rr, wrapping
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_id  = '0;
    w_rot_idx = '0;
    // Scan backwards so the last hit (closest to r_rr) wins
    for (int k = NCH - 1; k >= 0; k--) begin
      w_rot_idx = {1'b0, r_rr} + (CH_W+1)'(k);
      if (w_rot_idx >= c_NCH) w_rot_idx = w_rot_idx - c_NCH;
      if (r_pend[w_rot_idx[CH_W-1:0]] && !w_full) begin
        w_gnt_vld = 1'b1;
        w_gnt_id  = w_rot_idx[CH_W-1:0];
      end
    end
  end

  assign w_gnt_oh = w_gnt_vld ? (NCH'(1) << w_gnt_id) : '0;
  // A granted channel frees its slot this cycle, so its new edge is not a drop
  assign w_drop   = w_evt & r_pend & ~w_gnt_oh;

`ifdef TS_CAPTURE_FALLING_EN
  assign w_wr_word = {r_edge_lat[w_gnt_id], w_gnt_id, r_ts_lat[w_gnt_id]};
`else
  assign w_wr_word = {w_gnt_id, r_ts_lat[w_gnt_id]};
`endif

  // Per-channel pending flag and timestamp latch, plus arbiter pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend <= '0;
      r_rr   <= '0;
      for (int i = 0; i < NCH; i++) r_ts_lat[i] <= '0;
`ifdef TS_CAPTURE_FALLING_EN
      r_edge_lat <= '0;
`endif
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (w_evt[i] && (!r_pend[i] || w_gnt_oh[i])) begin
          r_pend[i]   <= 1'b1;
          r_ts_lat[i] <= r_cnt;
`ifdef TS_CAPTURE_FALLING_EN
          r_edge_lat[i] <= w_rise[i];
`endif
        end else if (w_gnt_oh[i]) begin
          r_pend[i] <= 1'b0;
        end
      end
      if (w_gnt_vld) r_rr <= (w_gnt_id == c_LAST_CH) ? '0 : w_gnt_id + 1'b1;
    end
  end

  // Count of channels losing an event this cycle
  always_comb begin
    w_drop_n = '0;
    for (int i = 0; i < NCH; i++) w_drop_n = w_drop_n + {{CH_W{1'b0}}, w_drop[i]};
  end

  assign w_drop_sum = {1'b0, r_drop} + {{(16-CH_W){1'b0}}, w_drop_n};

  // Saturating dropped-event counter
  always_ff @(posedge clk) begin
    if (rst)                r_drop <= '0;
    else if (w_drop_sum[16]) r_drop <= 16'hFFFF;
    else                    r_drop <= w_drop_sum[15:0];
  end

  // FIFO storage; contents need no reset since the pointers qualify them
  always_ff @(posedge clk) begin
    if (w_gnt_vld) r_mem[r_wptr] <= w_wr_word;
  end

  // r_level counts storage plus the output register; the output register
  // refills from storage whenever it is empty or being popped
  assign w_pop     = i_rd_en & r_out_vld;
  assign w_mem_cnt = r_level - {{(LVL_W-1){1'b0}}, r_out_vld};
  assign w_load    = (!r_out_vld || w_pop) && (w_mem_cnt != '0);

  // FIFO pointers, occupancy and fall-through output register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_level   <= '0;
      r_out_vld <= 1'b0;
      r_dout    <= '0;
    end else begin
      if (w_gnt_vld) r_wptr <= r_wptr + 1'b1;
      if (w_load) begin
        r_dout    <= r_mem[r_rptr];
        r_rptr    <= r_rptr + 1'b1;
        r_out_vld <= 1'b1;
      end else if (w_pop) begin
        r_out_vld <= 1'b0;
      end
      case ({w_gnt_vld, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_dout       = r_dout;
  assign o_empty      = ~r_out_vld;
  assign o_full       = w_full;
  assign o_level      = r_level;
  assign o_drop_count = r_drop;
  assign o_ts_now     = r_cnt;

endmodule
`default_nettype wire
